// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, op decode.
package muldiv_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } md_state_e;

    typedef struct packed {
        logic is_mul;
        logic is_div;
        logic is_signed;
        logic is_mthi;
        logic is_mtlo;
    } md_ctrl_t;

    // Reserved codes decode to all-zero controls, i.e. a silent no-op.
    function automatic md_ctrl_t decode_op(input logic [OP_W-1:0] op);
        md_ctrl_t c;
        c = '0;
        case (op)
            MD_MULT:  begin c.is_mul = 1'b1; c.is_signed = 1'b1; end
            MD_MULTU: c.is_mul = 1'b1;
            MD_DIV:   begin c.is_div = 1'b1; c.is_signed = 1'b1; end
            MD_DIVU:  c.is_div = 1'b1;
            MD_MTHI:  c.is_mthi = 1'b1;
            MD_MTLO:  c.is_mtlo = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic                        start;
    logic [muldiv_pkg::OP_W-1:0] op;
    logic [WIDTH-1:0]            a;
    logic [WIDTH-1:0]            b;
    logic                        busy;
    logic                        done;
    logic [WIDTH-1:0]            hi;
    logic [WIDTH-1:0]            lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_cond_neg.sv
// Conditional two's-complement: passes the value through or negates it.
module cond_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val_c
);

    assign o_val_c = i_neg ? WIDTH'((~i_val) + WIDTH'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-subtract step
// per cycle on magnitudes, then a single sign-fix cycle before HI/LO update.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam int unsigned       CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    md_state_e          r_state;
    md_state_e          w_next;
    md_ctrl_t           w_ctrl;
    logic               w_accept;
    logic               w_last;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_busy;
    logic               r_done;

    logic               w_sgn_a;
    logic               w_sgn_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_ctrl   = decode_op(bus.op);
    assign w_accept = bus.start && !r_busy;
    assign w_last   = (r_cnt == LAST);

    assign w_sgn_a  = w_ctrl.is_signed & bus.a[WIDTH-1];
    assign w_sgn_b  = w_ctrl.is_signed & bus.b[WIDTH-1];

    cond_neg #(.WIDTH(WIDTH)) u_mag_a (.i_val(bus.a), .i_neg(w_sgn_a), .o_val_c(w_mag_a));
    cond_neg #(.WIDTH(WIDTH)) u_mag_b (.i_val(bus.b), .i_neg(w_sgn_b), .o_val_c(w_mag_b));

    // Multiply: {r_acc, r_q} is the product/multiplier shift register, r_d the multiplicand.
    assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_d} : '0);

    // Divide: r_acc is the partial remainder, r_q shifts dividend out and quotient in.
    assign w_diff = {r_acc, r_q[WIDTH-1]} - {1'b0, r_d};
    assign w_ge   = ~w_diff[WIDTH];

    cond_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.i_val({r_acc, r_q}), .i_neg(r_neg_q), .o_val_c(w_prod_fix));
    cond_neg #(.WIDTH(WIDTH))   u_fix_quo  (.i_val(r_q),          .i_neg(r_neg_q), .o_val_c(w_quo_fix));
    cond_neg #(.WIDTH(WIDTH))   u_fix_rem  (.i_val(r_acc),        .i_neg(r_neg_r), .o_val_c(w_rem_fix));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_ctrl.is_mul)      w_next = MUL;
                else if (w_accept && w_ctrl.is_div) w_next = DIV;
            end
            MUL:     if (w_last) w_next = FIX;
            DIV:     if (w_last) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_d      <= '0;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (r_state == FIX);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_ctrl.is_mthi) r_hi <= bus.a;
                        if (w_ctrl.is_mtlo) r_lo <= bus.a;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_q      <= w_ctrl.is_div ? w_mag_a : w_mag_b;
                        r_d      <= w_ctrl.is_div ? w_mag_b : w_mag_a;
                        r_a      <= bus.a;
                        r_is_div <= w_ctrl.is_div;
                        r_neg_q  <= w_sgn_a ^ w_sgn_b;
                        r_neg_r  <= w_sgn_a;
                        r_div0   <= (bus.b == '0);
                    end
                end
                MUL: begin
                    r_acc <= w_mul_sum[WIDTH:1];
                    r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                DIV: begin
                    r_acc <= w_ge ? w_diff[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
                    r_q   <= {r_q[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    // Divide by zero reports all-ones quotient and the raw dividend.
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_div0) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, monitor pops on done.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 64'(bus.done), 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("result_hi", 64'(bus.hi), 64'(e[63:32]));
                chk("result_lo", 64'(bus.lo), 64'(e[31:0]));
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Accepting edge, then scramble operands to prove they were captured.
    task automatic release_in();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 3'($urandom_range(0, 5));
    endtask

    // Cycle-by-cycle busy/done/hold checks; optionally fires a stray start at cycle inj.
    task automatic track(input logic [31:0] eh, input logic [31:0] el, input int inj);
        for (int k = 1; k <= int'(W) + 2; k++) begin
            @(negedge clk);
            if (inj > 0 && k == inj + 1) bus.start = 1'b0;
            chk("busy", 64'(bus.busy), 64'(k <= int'(W) + 1));
            chk("done", 64'(bus.done), 64'(k == int'(W) + 2));
            if (k <= int'(W) + 1) begin
                chk("hold_hi", 64'(bus.hi), 64'(m_hi));
                chk("hold_lo", 64'(bus.lo), 64'(m_lo));
            end
            if (inj > 0 && k == inj) drive(3'd1, 32'd2, 32'd2);
        end
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int inj, input bit chain);
        if (!chain) @(negedge clk);
        exp_q.push_back({eh, el});
        drive(op, a, b);
        release_in();
        track(eh, el, inj);
    endtask

    task automatic mtx(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        drive(op, a, 32'h0);
        release_in();
        m_hi = eh;
        m_lo = el;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("mt_hi", 64'(bus.hi), 64'(m_hi));
            chk("mt_lo", 64'(bus.lo), 64'(m_lo));
            chk("mt_busy", 64'(bus.busy), 64'd0);
            chk("mt_done", 64'(bus.done), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(3'd4, 32'hFFFF, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        bus.start = 1'b0;
        rst = 1'b0;

        mtx(3'd4, 32'h0000_1234, 32'h0000_1234, 32'h0);
        mtx(3'd5, 32'h0000_5678, 32'h0000_1234, 32'h0000_5678);
        mtx(3'd6, 32'h0000_DEAD, 32'h0000_1234, 32'h0000_5678);

        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);
        run(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1'b0);
        run(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 1'b0);
        run(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
        run(3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 0, 1'b0);
        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 1'b0);
        run(3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 1'b0);
        run(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 1'b0);
        run(3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        5, 1'b0);

        // Second request issued in the done cycle of the first.
        run(3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0, 1'b0);
        run(3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 0, 1'b1);

        // Abort a MULTU with reset at cycle 10.
        @(negedge clk);
        drive(3'd1, 32'd5, 32'd6);
        release_in();
        for (int k = 1; k <= 10; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        m_hi = '0;
        m_lo = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("abort_done", 64'(bus.done), 64'd0);
        end

        run(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 0, 1'b0);

        repeat (2) @(negedge clk);
        chk("pending_results", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and HI/LO register width (even, >= 4).
REQ-002 Port clk SHALL be input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit, synchronous active-high reset.
REQ-004 Port start SHALL be input, 1 bit, request strobe sampled each rising edge.
REQ-005 Port op SHALL be input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
REQ-006 Ports a and b SHALL be inputs, WIDTH bits each: rs and rt operands (dividend a, divisor b).
REQ-007 Port busy SHALL be output, 1 bit, high while an iterative operation is in progress; the pipeline stalls mult/div/mfhi/mflo/mthi/mtlo on it.
REQ-008 Port done SHALL be output, 1 bit, one-cycle pulse marking HI/LO update by mult/div.
REQ-009 Ports hi and lo SHALL be outputs, WIDTH bits each, the architectural HI and LO registers.

Function
REQ-010 A request SHALL be accepted on an edge where start=1, busy=0 and rst=0; start while busy=1 SHALL be ignored with no state change.
REQ-011 Reserved op codes SHALL be accepted and ignored, with no busy, no done and no HI/LO change.
REQ-012 MTHI/MTLO SHALL write a into hi/lo at the accepting edge, leave the other register unchanged, and assert neither busy nor done.
REQ-013 a, b and op SHALL be captured at the accepting edge; later input changes SHALL NOT affect the result.
REQ-014 FSM states SHALL be IDLE, MUL, DIV and FIX: IDLE->MUL/DIV on accepted mult/div; MUL/DIV->FIX after WIDTH iteration cycles; FIX->IDLE after one cycle.
REQ-015 MUL SHALL perform one shift-add step per cycle on operand magnitudes, and DIV one restoring-subtract step per cycle.
REQ-016 For an accepting edge 0, busy SHALL be 1 in cycles 1..WIDTH+1, hi/lo SHALL update on the edge ending cycle WIDTH+1, and done=1, busy=0 in cycle WIDTH+2.
REQ-017 A new request SHALL be acceptable in the done cycle.
REQ-018 hi/lo SHALL hold their previous values throughout busy.
REQ-019 MULT/MULTU SHALL produce the 2*WIDTH-bit product {hi,lo}; in signed mode the magnitude product SHALL be negated in FIX when operand signs differ.
REQ-020 DIV/DIVU SHALL write quotient to lo and remainder to hi.
REQ-021 Signed quotient SHALL truncate toward zero, and the signed remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero (b=0, signed or unsigned) SHALL give lo = all ones and hi = a, with the normal latency.
REQ-023 Signed -2^(WIDTH-1) / -1 SHALL give lo = -2^(WIDTH-1) and hi = 0, with no error indication.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, hi=0 and lo=0, overriding start.
REQ-025 Reset during MUL/DIV/FIX SHALL abort the operation with no done pulse and no partial result written.

Structure
REQ-026 Package muldiv_pkg SHALL hold the op encodings (MD_MULT..MD_MTLO) and the FSM state type; the control decoder SHALL import the same encodings.
REQ-027 One sub-module, cond_neg (WIDTH-parametrised conditional two's-complement), SHALL be used for operand magnitudes and result sign fix; the rest SHALL be a single module.

Verification (WIDTH=32, accepting edge = cycle 0)
REQ-028 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy cycles 1–33, done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
REQ-030 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 MTHI 0x1234 while idle -> hi=0x1234 next cycle, lo unchanged, busy and done stay 0; start (MULTU 2x2) at cycle 5 of a running DIVU -> ignored, DIVU result intact.
REQ-032 MULTU started, rst=1 at cycle 10 -> busy=0, hi=lo=0 from cycle 11, done never pulses; a fresh MULTU 3x4 afterwards -> lo=12.
REQ-033 Back-to-back run: second request at the done cycle -> accepted, second done exactly 34 cycles later.
